// File: rtl/ins_cache.sv
// ins_cache -- direct-mapped instruction cache with a fixed-latency refill.
//
// Address decode: iaddr[3:2] selects the 32-bit word inside a 128-bit line,
// the next log2(LINES) bits select the line, and the remaining upper bits
// form the tag. On a miss the FSM latches index and tag, then waits
// MISS_LATENCY cycles before writing imem_in into that line.
//
// Optional feature: define INS_CACHE_MISS_NOP_EN to force oins to zero
// (a NOP-like word) whenever ohit is low. Without the macro, oins always
// shows the selected word of the indexed line, stale or not.

module ins_cache #(
   parameter int LINES        = 16,
   parameter int MISS_LATENCY = 3
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [31:0]  iaddr,
   input  logic [127:0] imem_in,
   output logic         ohit,
   output logic [31:0]  oins
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 32 - 4 - IDX_W;

   localparam logic [3:0] LAST_CNT = 4'(MISS_LATENCY - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_FILL = 1'b1;

   // Address fields
   logic [1:0]       offset;
   logic [IDX_W-1:0] index;
   logic [TAG_W-1:0] tag;

   assign offset = iaddr[3:2];
   assign index  = iaddr[4 +: IDX_W];
   assign tag    = iaddr[31 -: TAG_W];

   // Byte-lane bits carry no meaning for word fetches.
   logic unused_byte_bits;
   assign unused_byte_bits = ^iaddr[1:0];

   // Line storage
   logic [LINES-1:0]   valid_q;
   logic [TAG_W-1:0]   tag_q  [LINES];
   logic [127:0]       data_q [LINES];

   // Miss-handling state
   logic [0:0]       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
   logic [TAG_W-1:0] fill_tag_q, fill_tag_d;
   logic             fill_done;

   logic [127:0] sel_line;
   logic [31:0]  sel_word;

   // Lookup: hit detection and word select are purely combinational.
   always_comb begin
      sel_line = data_q[index];
      sel_word = sel_line[32*offset +: 32];
      ohit     = valid_q[index] && (tag_q[index] == tag);
`ifdef INS_CACHE_MISS_NOP_EN
      oins     = ohit ? sel_word : 32'h0000_0000;
`else
      oins     = sel_word;
`endif
   end

   assign fill_done = (state_q == ST_FILL) && (cnt_q == LAST_CNT);

   // Next-state logic for the miss FSM and its latched fill target.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a
      // variable unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      fill_idx_d = fill_idx_q;
      fill_tag_d = fill_tag_q;
      case (state_q)
         ST_IDLE: begin
            if (!ohit) begin
               state_d    = ST_FILL;
               cnt_d      = 4'd0;
               fill_idx_d = index;
               fill_tag_d = tag;
            end
         end
         ST_FILL: begin
            if (cnt_q == LAST_CNT) begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // FSM, counter and fill-target registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         fill_idx_q <= '0;
         fill_tag_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         fill_idx_q <= fill_idx_d;
         fill_tag_q <= fill_tag_d;
      end
   end

   // Valid bits: cleared by reset, set when a fill completes.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q <= '0;
      end else if (fill_done) begin
         valid_q[fill_idx_q] <= 1'b1;
      end
   end

   // Tag and data arrays written on fill completion.
   // NOTE: these arrays are deliberately not reset; the cleared valid bits
   // already make their contents irrelevant, and an un-reset array maps to
   // plain RAM. A fill in progress cannot complete under reset because
   // state_q is forced to IDLE asynchronously.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         tag_q[fill_idx_q]  <= fill_tag_q;
         data_q[fill_idx_q] <= imem_in;
      end
   end

endmodule

// File: tb/tb_ins_cache.sv
// tb_ins_cache -- directed self-checking bench for ins_cache (default
// parameters LINES=16, MISS_LATENCY=3). Inputs change 1 ns after a rising
// edge and outputs are sampled at that point, away from the active edge.
// Build with +define+INS_CACHE_MISS_NOP_EN to exercise the NOP-on-miss mode.

module tb_ins_cache;

   logic         clk;
   logic         rstn;
   logic [31:0]  iaddr;
   logic [127:0] imem_in;
   logic         ohit;
   logic [31:0]  oins;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [127:0] LINE_A = {32'hDEADBEEF, 32'hABABABAB, 32'hCDCDCDCD, 32'hEFEFEFEF};
   localparam logic [127:0] LINE_B = {32'h11111113, 32'h11111112, 32'h11111111, 32'h11111110};
   localparam logic [127:0] LINE_C = {32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000};
   localparam logic [127:0] LINE_X = {32'h99999999, 32'h88888888, 32'h77777777, 32'h66666666};

   ins_cache #(.LINES(16), .MISS_LATENCY(3)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .iaddr   (iaddr),
      .imem_in (imem_in),
      .ohit    (ohit),
      .oins    (oins)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a missing address, confirm the miss lasts exactly
   // MISS_LATENCY+1 edges, then confirm the hit and the returned word.
   task automatic do_miss(input string tag, input logic [31:0] addr,
                          input logic [127:0] line, input logic [31:0] exp_word);
      iaddr   = addr;
      imem_in = line;
      #1;
      check({tag, "_miss"}, {31'd0, ohit}, 32'd0);
`ifdef INS_CACHE_MISS_NOP_EN
      check({tag, "_nop"}, oins, 32'h0000_0000);
`endif
      repeat (3) tick();
      check({tag, "_still_miss"}, {31'd0, ohit}, 32'd0);
`ifdef INS_CACHE_MISS_NOP_EN
      check({tag, "_nop_late"}, oins, 32'h0000_0000);
`endif
      tick();
      check({tag, "_hit"}, {31'd0, ohit}, 32'd1);
      check({tag, "_word"}, oins, exp_word);
   endtask

   initial begin
      rstn    = 1'b0;
      iaddr   = 32'd7;
      imem_in = LINE_A;
      #12;
      check("rst_ohit", {31'd0, ohit}, 32'd0);
      rstn = 1'b1;

      // First fill: line 0, word 1 addressed by iaddr=7.
      do_miss("fill0", 32'd7, LINE_A, 32'hCDCDCDCD);

      // Every word of line 0 hits; a changed imem_in must not be written.
      imem_in = LINE_X;
      iaddr = 32'd0;  #1; check("w0_hit", {31'd0, ohit}, 32'd1); check("w0", oins, 32'hEFEFEFEF); tick();
      iaddr = 32'd4;  #1; check("w1_hit", {31'd0, ohit}, 32'd1); check("w1", oins, 32'hCDCDCDCD); tick();
      iaddr = 32'd8;  #1; check("w2_hit", {31'd0, ohit}, 32'd1); check("w2", oins, 32'hABABABAB); tick();
      iaddr = 32'd12; #1; check("w3_hit", {31'd0, ohit}, 32'd1); check("w3", oins, 32'hDEADBEEF);
      repeat (5) tick();
      iaddr = 32'd0;  #1; check("no_refill", oins, 32'hEFEFEFEF);

      // Line 1 fill; iaddr wanders to a conflicting address mid-fill
      // and must not redirect the fill.
      iaddr   = 32'd16;
      imem_in = LINE_B;
      #1;
      check("l1_miss", {31'd0, ohit}, 32'd0);
      tick();
      iaddr = 32'h200;
      tick();
      tick();
      iaddr = 32'd16;
      tick();
      check("l1_hit", {31'd0, ohit}, 32'd1);
      check("l1_w0", oins, 32'h11111110);
      iaddr = 32'd20; #1; check("l1_w1", oins, 32'h11111111);
      iaddr = 32'd24; #1; check("l1_w2", oins, 32'h11111112);
      iaddr = 32'd28; #1; check("l1_w3", oins, 32'h11111113);
      check("l1_w3_hit", {31'd0, ohit}, 32'd1);
      iaddr = 32'd0;  #1; check("l0_kept", {31'd0, ohit}, 32'd1);
      check("l0_kept_w", oins, 32'hEFEFEFEF);
      tick();

      // Conflict on index 0 replaces line 0.
      do_miss("repl", 32'h100, LINE_C, 32'hC0000000);
      iaddr = 32'd0;
      #1;
      check("old_tag_miss", {31'd0, ohit}, 32'd0);
`ifdef INS_CACHE_MISS_NOP_EN
      check("old_tag_nop", oins, 32'h0000_0000);
`else
      check("old_tag_stale", oins, 32'hC0000000);
`endif

      // iaddr=0 misses, a fill starts; abort it with reset mid-fill.
      imem_in = LINE_A;
      tick();
      tick();
      iaddr = 32'd16;
      #1;
      check("fill_lookup_hit", {31'd0, ohit}, 32'd1);
      rstn = 1'b0;
      #1;
      check("rst_mid_fill", {31'd0, ohit}, 32'd0);
      repeat (3) tick();
      check("rst_held", {31'd0, ohit}, 32'd0);
      rstn = 1'b1;

      // FSM starts from IDLE: a previously valid address misses and takes
      // exactly the full latency.
      do_miss("post_rst", 32'd16, LINE_B, 32'h11111110);
      iaddr = 32'd0;
      #1;
      check("aborted_not_written", {31'd0, ohit}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ins_cache.md
INS_CACHE -- requirements
Module: ins_cache

Interface
REQ-001 SHALL provide parameter LINES, default 16, the number of direct-mapped cache lines (power of two, 2..256).
REQ-002 SHALL provide parameter MISS_LATENCY, default 3, the number of clock cycles from miss detection to line fill (1..15).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit, the reset, asynchronous and active-low.
REQ-005 SHALL have port iaddr, input, 32 bits, the instruction byte address.
REQ-006 SHALL have port imem_in, input, 128 bits, the refill line from instruction memory; word k is imem_in[32k+31:32k].
REQ-007 SHALL have port ohit, output, 1 bit, high when iaddr hits a valid line.
REQ-008 SHALL have port oins, output, 32 bits, the instruction word selected by iaddr.

Function
REQ-009 SHALL decode iaddr as offset = iaddr[3:2] (iaddr[1:0] ignored, no alignment fault), index = the next log2(LINES) bits, and tag = the remaining upper bits.
REQ-010 SHALL store per line: valid bit, tag and 128-bit data.
REQ-011 SHALL drive ohit combinationally as valid[index] AND stored tag[index] equals the iaddr tag.
REQ-012 SHALL drive oins combinationally as word[offset] of line[index].
REQ-013 SHALL implement FSM states IDLE and FILL, plus a 4-bit cycle counter.
REQ-014 In IDLE with ohit=0 at a rising edge, SHALL latch index and tag, clear the counter, and enter FILL.
REQ-015 In FILL, SHALL increment the counter each cycle.
REQ-016 When counter equals MISS_LATENCY-1, SHALL write imem_in, the latched tag and valid=1 into the latched line, then return to IDLE; ohit rises in the following cycle if iaddr still maps to that line.
REQ-017 A miss-to-hit delay SHALL therefore be MISS_LATENCY+1 rising edges.
REQ-018 Changes on iaddr during FILL SHALL NOT alter the latched index/tag; the fill completes to the original line.
REQ-019 A new miss SHALL be serviced only after returning to IDLE; there SHALL be no back-to-back fill without one IDLE cycle.
REQ-020 A fill SHALL overwrite any previous content of the target line (direct-mapped replacement).
REQ-021 While in IDLE with ohit=1, state SHALL be unchanged.

Reset
REQ-022 rstn=0 SHALL immediately clear all valid bits, force the FSM to IDLE and the counter to 0; ohit SHALL be 0.
REQ-023 Tag and data arrays SHALL NOT need reset.
REQ-024 Reset asserted during FILL SHALL abort the fill with no line written.
REQ-025 While rstn=0, no miss SHALL be started.

Configuration
REQ-026 With macro INS_CACHE_MISS_NOP_EN defined, oins SHALL be forced to 32'h00000000 whenever ohit=0.
REQ-027 Without INS_CACHE_MISS_NOP_EN, oins SHALL show the selected word of line[index] regardless of ohit, including stale or uninitialized data.

Verification
REQ-028 Reset, then iaddr=7 with imem_in={DEADBEEF,ABABABAB,CDCDCDCD,EFEFEFEF} (MSW first) -> ohit=0 initially; ohit=1 after 4 rising edges; oins=32'hCDCDCDCD.
REQ-029 After that fill, iaddr=0,4,8,12 in turn -> ohit=1 each; oins=EFEFEFEF, CDCDCDCD, ABABABAB, DEADBEEF; no FILL entered.
REQ-030 iaddr=16 (next index) -> ohit=0, fill of line 1; after the fill, iaddr=20,24,28 hit with the words at offsets 1,2,3.
REQ-031 iaddr=0x100 (same index 0, different tag) after line 0 is filled -> miss, line 0 replaced; iaddr=0 then misses.
REQ-032 Assert rstn=0 mid-FILL -> ohit=0 at once, FSM in IDLE; after release, a previously valid address misses.
REQ-033 With INS_CACHE_MISS_NOP_EN defined, on any miss -> oins=32'h00000000 until ohit=1.
